// File: rtl/eq_pkg.sv
// Shared sign-magnitude types, constants and sm<->two's complement conversions.
// tc_to_sm saturation is chosen by the caller (see ACC_SATURATE_EN in sm_sat_pack).
package eq_pkg;

   typedef logic [15:0] sm16_t;

   localparam int          SM_SIGN_BIT = 15;
   localparam logic [14:0] SM_MAG_MAX  = 15'h7FFF;

   // Negative zero (0x8000) naturally maps to 0 because -0 == 0.
   function automatic logic signed [31:0] sm_to_tc(input sm16_t v);
      logic signed [31:0] mag;
      mag = {17'd0, v[14:0]};
      return v[SM_SIGN_BIT] ? -mag : mag;
   endfunction

   function automatic sm16_t tc_to_sm(input logic signed [31:0] v, input logic sat);
      logic [31:0] mag;
      logic [14:0] m;
      mag = v[31] ? 32'(-v) : 32'(v);
      if (sat && (mag > {17'd0, SM_MAG_MAX}))
         m = SM_MAG_MAX;
      else
         m = mag[14:0];
      // A zero magnitude is always emitted as positive zero.
      return (m == 15'd0) ? 16'h0000 : {v[31], m};
   endfunction

endpackage

// File: rtl/sm_sat_pack.sv
// Converts the two's complement accumulator to sign-magnitude Q1.15.
// Define ACC_SATURATE_EN to clamp magnitudes above 0x7FFF instead of wrapping.
module sm_sat_pack
   import eq_pkg::*;
#(
   parameter int ACC_W = 20
) (
   input  logic signed [ACC_W-1:0] acc,
   output sm16_t                   y
);

`ifdef ACC_SATURATE_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif

   assign y = tc_to_sm(32'(acc), SAT);

endmodule

// File: rtl/tap_accumulator.sv
// Accumulates sign-magnitude tap products into one filtered sample per packet.
// Output saturation is enabled by defining ACC_SATURATE_EN.
module tap_accumulator
   import eq_pkg::*;
#(
   parameter int GUARD_BITS = 4,
   parameter int MAX_TAPS   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] prod_i,
   input  logic        prod_valid_i,
   input  logic        prod_last_i,
   output logic        prod_ready_o,
   output logic [15:0] y_o,
   output logic        y_valid_o,
   input  logic        y_ready_i,
   output logic        tap_err_o
);

   localparam int ACC_W = 16 + GUARD_BITS;
   localparam int CNT_W = $clog2(MAX_TAPS + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]              state;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        count;

   logic                    accept;
   logic                    finish;
   logic signed [ACC_W-1:0] tc_beat;
   logic signed [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0]        count_inc;
   sm16_t                   y_conv;

   assign prod_ready_o = (state != DONE);

   // The first beat of a sample replaces whatever acc/count held before.
   always_comb begin
      accept    = prod_valid_i && prod_ready_o;
      tc_beat   = ACC_W'(sm_to_tc(prod_i));
      acc_sum   = (state == IDLE) ? tc_beat : acc + tc_beat;
      count_inc = ((state == IDLE) ? '0 : count) + CNT_W'(1);
      finish    = accept && (prod_last_i || (count_inc >= CNT_W'(MAX_TAPS)));
   end

   sm_sat_pack #(.ACC_W(ACC_W)) u_pack (
      .acc (acc_sum),
      .y   (y_conv)
   );

   // The result is captured on the terminating beat so y_valid_o follows one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         y_o       <= 16'h0000;
         y_valid_o <= 1'b0;
         tap_err_o <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc   <= acc_sum;
                  count <= count_inc;
                  if (finish) begin
                     state     <= DONE;
                     y_o       <= y_conv;
                     y_valid_o <= 1'b1;
                     tap_err_o <= !prod_last_i;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            DONE: begin
               if (y_ready_i) begin
                  state     <= IDLE;
                  acc       <= '0;
                  count     <= '0;
                  y_valid_o <= 1'b0;
                  tap_err_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tap_accumulator.sv
// Directed scoreboard bench for tap_accumulator; expectations come from an integer model.
// Build with ACC_SATURATE_EN defined to check the saturating variant.
module tb_tap_accumulator;

   localparam int MAX_TAPS = 16;

   typedef struct {
      logic [15:0] y;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [15:0] prodI;
   logic        prodValid;
   logic        prodLast;
   logic        prodReady;
   logic [15:0] yO;
   logic        yValid;
   logic        yReady;
   logic        tapErr;

   exp_t expQ[$];
   int   compareCount;
   int   failCount;
   int   modelSum;
   int   modelCount;

   tap_accumulator #(.GUARD_BITS(4), .MAX_TAPS(MAX_TAPS)) dut (
      .clk          (clk),
      .rst          (rst),
      .prod_i       (prodI),
      .prod_valid_i (prodValid),
      .prod_last_i  (prodLast),
      .prod_ready_o (prodReady),
      .y_o          (yO),
      .y_valid_o    (yValid),
      .y_ready_i    (yReady),
      .tap_err_o    (tapErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int smToInt(input logic [15:0] v);
      int m;
      m = int'(v[14:0]);
      return v[15] ? -m : m;
   endfunction

   function automatic logic [15:0] modelOut(input int sum);
      int mag;
      mag = (sum < 0) ? -sum : sum;
`ifdef ACC_SATURATE_EN
      if (mag > 32767) mag = 32767;
`else
      mag = mag % 32768;
`endif
      if (mag == 0) return 16'h0000;
      return {(sum < 0), mag[14:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one beat and advances the model; a completed sample is queued for checking.
   task automatic applyStimulus(input logic [15:0] d, input logic last);
      int w;
      w = 0;
      while (prodReady !== 1'b1 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("ready_wait", 32'(w < 20), 32'd1);
      prodI     = d;
      prodLast  = last;
      prodValid = 1'b1;
      @(posedge clk); #1;
      prodValid = 1'b0;
      prodLast  = 1'b0;
      modelSum += smToInt(d);
      modelCount++;
      if (last || modelCount == MAX_TAPS) begin
         expQ.push_back('{y: modelOut(modelSum), err: !last});
         modelSum   = 0;
         modelCount = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      int   w;
      exp_t e;
      w = 0;
      while (yValid !== 1'b1 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check({tag, "_latency"}, 32'(w), 32'd0);
      if (expQ.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = expQ.pop_front();
         check({tag, "_y"}, 32'(yO), 32'(e.y));
         check({tag, "_err"}, 32'(tapErr), 32'(e.err));
      end
      yReady = 1'b1;
      @(posedge clk); #1;
      yReady = 1'b0;
      check({tag, "_valid_drop"}, 32'(yValid), 32'd0);
      check({tag, "_ready_back"}, 32'(prodReady), 32'd1);
   endtask

   task automatic pulseReset(input string tag);
      #2 rst = 1'b1;
      #1;
      check({tag, "_y"}, 32'(yO), 32'd0);
      check({tag, "_valid"}, 32'(yValid), 32'd0);
      check({tag, "_err"}, 32'(tapErr), 32'd0);
      check({tag, "_ready"}, 32'(prodReady), 32'd1);
      #2 rst = 1'b0;
      modelSum   = 0;
      modelCount = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      compareCount = 0;
      failCount    = 0;
      modelSum     = 0;
      modelCount   = 0;
      rst       = 1'b1;
      prodI     = 16'h0000;
      prodValid = 1'b0;
      prodLast  = 1'b0;
      yReady    = 1'b0;
      #1;
      check("reset_y", 32'(yO), 32'd0);
      check("reset_valid", 32'(yValid), 32'd0);
      check("reset_err", 32'(tapErr), 32'd0);
      check("reset_ready", 32'(prodReady), 32'd1);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus(16'h0003, 1'b0);
      applyStimulus(16'h8001, 1'b1);
      checkOutput("pos_minus_neg");

      for (int i = 0; i < 4; i++) applyStimulus(16'h7FFF, i == 3);
      checkOutput("four_max");

      applyStimulus(16'h8000, 1'b1);
      checkOutput("neg_zero");
      applyStimulus(16'h8005, 1'b1);
      checkOutput("single_neg");

      applyStimulus(16'h0007, 1'b0);
      applyStimulus(16'h8007, 1'b1);
      checkOutput("cancel_zero");

      applyStimulus(16'h4000, 1'b0);
      applyStimulus(16'h4000, 1'b1);
      checkOutput("just_over");

      for (int i = 0; i < 4; i++) applyStimulus(16'hFFFF, i == 3);
      checkOutput("four_min");

      // Output stall: a competing beat must be refused while the result waits.
      applyStimulus(16'h0009, 1'b1);
      for (int i = 0; i < 3; i++) begin
         prodI     = 16'h1234;
         prodLast  = 1'b1;
         prodValid = 1'b1;
         check("stall_valid", 32'(yValid), 32'd1);
         check("stall_y", 32'(yO), 32'(expQ[0].y));
         check("stall_ready", 32'(prodReady), 32'd0);
         @(posedge clk); #1;
      end
      prodValid = 1'b0;
      prodLast  = 1'b0;
      checkOutput("stall_release");

      for (int i = 0; i < 16; i++) applyStimulus(16'h0001, 1'b0);
      checkOutput("max_taps_cut");
      for (int i = 0; i < 16; i++) applyStimulus(16'h0001, i == 15);
      checkOutput("max_taps_last");

      applyStimulus(16'h0001, 1'b0);
      applyStimulus(16'h0002, 1'b0);
      pulseReset("rst_accum");
      applyStimulus(16'h0004, 1'b1);
      checkOutput("after_rst_accum");

      applyStimulus(16'h0033, 1'b1);
      pulseReset("rst_done");
      void'(expQ.pop_front());
      applyStimulus(16'h8004, 1'b1);
      checkOutput("after_rst_done");

      for (int s = 0; s < 3; s++) begin
         n = $urandom_range(1, 5);
         for (int b = 0; b < n; b++) applyStimulus(16'($urandom_range(0, 65535)), b == n - 1);
         checkOutput("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
